// File: rtl/hpu_pkg.sv
// Shared widths, word/beat types and half-index constants for the ping-pong
// source buffer.
package hpu_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [2*DATA_W-1:0] beat_t;

  localparam logic HALF0 = 1'b0;
  localparam logic HALF1 = 1'b1;

endpackage

// File: rtl/src_bank.sv
// One buffer half: even/odd word arrays written as a 64-bit pair and read as a
// single 32-bit word through a registered port.
module src_bank
  import hpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-2:0] waddr_i,
  input  beat_t             wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output word_t             rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_W - 1);

  word_t even_q [DEPTH];
  word_t odd_q  [DEPTH];
  word_t rdata_q;

  // Storage is deliberately unreset; stale words are visible until rewritten.
  always_ff @(posedge clk) begin
    if (we_i) begin
      even_q[waddr_i] <= wdata_i[DATA_W-1:0];
      odd_q[waddr_i]  <= wdata_i[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= raddr_i[0] ? odd_q[raddr_i[ADDR_W-1:1]]
                            : even_q[raddr_i[ADDR_W-1:1]];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/src_buf.sv
// Ping-pong input buffer: DMA stream fills one half while cores read the other.
// Optional sticky overflow/underflow flags are built when SRC_BUF_ERR_EN is defined.
module src_buf
  import hpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stream_v,
  input  logic [ADDR_W-2:0] stream_a,
  input  beat_t             stream_d,
  input  logic              stream_last,
  output logic              stream_ready,
  output logic              rd_avail,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output word_t             rd_data,
  output logic              rd_valid,
  input  logic              rd_done,
  output logic              p,
  output logic [1:0]        err
);

  logic [1:0] full_q, full_d;
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic       rd_valid_q;
  logic       sel_q;
  logic       wr_fire, last_fire, rd_fire, rel_fire;
  word_t      rdata0, rdata1;

  assign stream_ready = ~full_q[wp_q];
  assign rd_avail     = full_q[rp_q];

  assign wr_fire   = stream_v & stream_ready;
  assign last_fire = wr_fire & stream_last;
  assign rd_fire   = rd_en & rd_avail;
  assign rel_fire  = rd_done & rd_avail;

  // Set and clear never target the same half: a half being filled is not full.
  always_comb begin
    full_d = full_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (rel_fire) begin
      full_d[rp_q] = 1'b0;
      rp_d         = ~rp_q;
    end
    if (last_fire) begin
      full_d[wp_q] = 1'b1;
      wp_d         = ~wp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= 2'b00;
      wp_q       <= HALF0;
      rp_q       <= HALF0;
      rd_valid_q <= 1'b0;
      sel_q      <= HALF0;
    end else begin
      full_q     <= full_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      rd_valid_q <= rd_fire;
      if (rd_fire) sel_q <= rp_q;
    end
  end

  src_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_fire & (wp_q == HALF0)),
    .waddr_i (stream_a),
    .wdata_i (stream_d),
    .re_i    (rd_fire & (rp_q == HALF0)),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  src_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_fire & (wp_q == HALF1)),
    .waddr_i (stream_a),
    .wdata_i (stream_d),
    .re_i    (rd_fire & (rp_q == HALF1)),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  // The read mux follows the half last read, so rd_data holds across a release.
  assign rd_data  = (sel_q == HALF1) ? rdata1 : rdata0;
  assign rd_valid = rd_valid_q;
  assign p        = rp_q;

`ifdef SRC_BUF_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_q | {rd_en & ~rd_avail, stream_v & ~stream_ready};
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

endmodule

// File: doc/src_buf.md
Name: src_buf

Overview:
- Ping-pong input buffer feeding the execution cores; it mirrors dst_buf on the input side.
- The write side accepts a 64-bit DMA stream and splits each beat into two 32-bit words, stored in even and odd banks.
- The read side serves 32-bit words to the cores with a registered, 1-cycle-latency read port.
- Two halves (bank pairs) alternate: one fills while the other is read, with full/release handshakes between them.

Parameters:
- ADDR_W, 6, word address width; 64 x 32-bit words per half.
- DATA_W, 32, core-side word width; the stream width is 2*DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- stream_v  in  1  stream beat valid.
- stream_a  in  ADDR_W-1  beat address; word pair {2a+1, 2a}.
- stream_d  in  2*DATA_W  beat data; [31:0] goes to the even word, [63:32] to the odd word.
- stream_last  in  1  final beat of the current half.
- stream_ready  out  1  write half is free (accepting beats).
- rd_avail  out  1  read half is full and readable.
- rd_en  in  1  core read request.
- rd_addr  in  ADDR_W  word address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data valid this cycle.
- rd_done  in  1  core releases the read half.
- p  out  1  index of the current read half.
- err  out  2  sticky errors: [0] overflow, [1] underflow.

Behaviour:
- State:
  - full[1:0]: per-half full flags.
  - wp: write-half index.
  - rp: read-half index; p = rp.
  - Each half is two 32-entry x 32-bit arrays (even/odd). Array contents are not reset.
- Reset (async assert, sync deassert use): full=0, wp=0, rp=0, rd_data=0, rd_valid=0, err=0.
- stream_ready = ~full[wp]. rd_avail = full[rp]. Both are combinational from the flags.
- Write:
  - Accepted when stream_v & stream_ready.
  - Even[wp][stream_a] <= stream_d[31:0]; odd[wp][stream_a] <= stream_d[63:32].
  - Accepted with stream_last: full[wp] <= 1 and wp toggles at the same edge.
  - Beats need not be in address order or complete. Unwritten words hold stale data.
- Write when not ready (stream_v & ~stream_ready): the beat is dropped, no state changes, and the overflow condition is raised.
- Read:
  - rd_en & rd_avail: at the next edge, rd_data <= (rd_addr[0] ? odd : even)[rp][rd_addr[5:1]] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its previous value.
  - Latency is exactly 1 cycle. Back-to-back reads every cycle are supported.
- Read when not available (rd_en & ~rd_avail): ignored, rd_valid=0, and the underflow condition is raised.
- Release: rd_done & full[rp] sets full[rp] <= 0 and toggles rp. rd_done with ~full[rp] is ignored.
- Simultaneous events:
  - rd_en and rd_done in the same cycle: the read uses the pre-toggle rp, so rd_valid returns old-half data.
  - stream_last on wp and rd_done on rp in the same cycle: both take effect. If wp==rp, the half is released and refilled correctly next cycle (ordering: the set applies to wp, the clear to rp; they are distinct when both halves are in use).
  - Same-cycle write and read on the same half cannot occur, because a half is never both writable and readable.
- Both halves full: stream_ready=0 until rd_done.
- Both halves empty: rd_avail=0.
- Reset mid-operation: all flags and pointers clear immediately. Partially filled data is abandoned; a bench must not expect rd_valid until a new fill completes.

Optional Feature:
- SRC_BUF_ERR_EN defined:
  - err[0] is set by a dropped stream beat; err[1] is set by an ignored rd_en.
  - Both bits are sticky until rst_n.
- Not defined: err is tied to 2'b00 and no detection logic is generated.

Decomposition:
- Shared package (hpu_pkg):
  - ADDR_W and DATA_W localparams.
  - Typedef word_t (32-bit) and beat_t (64-bit).
  - Half-index constants HALF0/HALF1.
- Sub-module src_bank: one half, holding the even/odd arrays, 64-bit write and 32-bit registered read. Instantiated twice.
- The top level holds the flags, pointers, handshakes and error logic.

Test Plan:
- Fill half 0: 32 beats with a=i, d={32'(2i+1), 32'(2i)}, last on i=31.
  - Expected: full=01, stream_ready=1, rd_avail=1, p=0.
  - Reads 0..63 on consecutive cycles return data=addr, each 1 cycle later, with rd_valid held continuously.
- Ping-pong:
  - While reading half 0, fill half 1 with data+100. Assert rd_done.
  - Expected: p=1, and rd_addr=5 returns 105.
- Overflow:
  - Fill both halves, then send a beat a=3, d=all-ones.
  - Expected: stream_ready=0, beat dropped, half contents unchanged, err[0]=1 (0 without the macro).
- Underflow:
  - rd_en with rd_addr=7 after reset.
  - Expected: rd_valid stays 0, err[1]=1, rd_done ignored (p stays 0).
- Simultaneous events:
  - rd_en(addr 2) and rd_done in one cycle, with stream_last completing the other half in the same cycle.
  - Expected: next cycle returns old-half word 2, rp toggles, full=10.
- Reset:
  - Pulse rst_n low mid-read and mid-fill.
  - Expected: immediately rd_valid=0, rd_data=0, full=00, p=0, err=0, stream_ready=1.
